// File: rtl/flash_prefetch_pkg.sv
// Shared FSM encoding and address-field helpers for the flash prefetch line buffer.
package flash_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL_REQ,
        ST_FILL_GAP,
        ST_RESP
    } state_e;

    localparam int LINE_WORDS_DEF = 4;
    localparam int IW             = $clog2(LINE_WORDS_DEF);

    typedef struct packed {
        logic [63:0] tag;
        logic [63:0] idx;
    } adr_fields_t;

    // Byte address -> {tag, word index}; the two byte-offset bits are dropped.
    function automatic adr_fields_t split_adr(input logic [63:0] adr, input int iw);
        adr_fields_t f;
        f.tag = adr >> (2 + iw);
        f.idx = (adr >> 2) & ((64'd1 << iw) - 64'd1);
        return f;
    endfunction

endpackage

// File: rtl/flash_prefetch_wb_line_buf.sv
// One-line read buffer: word storage, line tag and valid bit with a hit compare.
module flash_line_buf #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2,
    parameter int TAG_W      = 28
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o,
    input  logic [TAG_W-1:0] cmp_tag_i,
    output logic             hit_o,
    input  logic             load_tag_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             set_valid_i,
    input  logic             clr_valid_i
);

    logic [31:0]      mem_q [LINE_WORDS];
    logic [TAG_W-1:0] tag_q;
    logic             valid_q;

    // Storage has no reset: it is never read while the line is invalid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Clear wins over set so a late invalidate is never lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_tag_i) begin
                tag_q <= tag_i;
            end
            if (clr_valid_i) begin
                valid_q <= 1'b0;
            end else if (set_valid_i) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
    assign hit_o     = valid_q && (tag_q == cmp_tag_i);

endmodule

// File: rtl/flash_prefetch_wb.sv
// Wishbone read-prefetch line buffer in front of the spimemio flash data port.
module flash_prefetch_wb
    import flash_prefetch_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [ADDR_W-1:0] wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    input  logic              wbm_ack_i,
    input  logic [31:0]       wbm_dat_i,
    input  logic              invalidate_i,
    output logic [15:0]       miss_count_o
);

    localparam int IWL = $clog2(LINE_WORDS);
    localparam int TW  = ADDR_W - 2 - IWL;

    state_e            state_q;
    logic [IWL-1:0]    beat_q;
    logic [IWL-1:0]    idx_q;
    logic [TW-1:0]     tag_q;
    logic              pend_q;
    logic [15:0]       miss_q;
    logic [31:0]       dat_q;
    logic              fill_q;
    logic [ADDR_W-1:0] madr_q;

    adr_fields_t       adr_f;
    logic [TW-1:0]     req_tag;
    logic [IWL-1:0]    req_idx;
    logic [IWL-1:0]    rd_idx;
    logic [31:0]       rd_data;
    logic              req;
    logic              hit;
    logic              last_beat;
    logic              beat_done;
    logic              load_tag;
    logic              set_valid;
    logic              clr_valid;
    logic [31:0]       fill_dat_d;
    logic              unused_sel;

    assign unused_sel = ^wbs_sel_i;

    always_comb begin
        adr_f     = split_adr(64'(wbs_adr_i), IWL);
        req_tag   = TW'(adr_f.tag);
        req_idx   = IWL'(adr_f.idx);
        req       = wbs_cyc_i & wbs_stb_i;
        rd_idx    = (state_q == ST_IDLE) ? req_idx : idx_q;
        last_beat = (beat_q == IWL'(LINE_WORDS - 1));
        beat_done = (state_q == ST_FILL_REQ) & wbm_ack_i;
        load_tag  = beat_done & last_beat;
        // An invalidate seen at any point of the fill keeps the new line invalid.
        set_valid = load_tag & ~pend_q & ~invalidate_i;
        clr_valid = invalidate_i
                  | ((state_q == ST_IDLE) & req & ~wbs_we_i & ~hit);
        // The requested word may be the one arriving on this very beat.
        fill_dat_d = (idx_q == beat_q) ? wbm_dat_i : rd_data;
    end

    flash_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IWL),
        .TAG_W      (TW)
    ) u_line_buf (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .wr_en_i     (beat_done),
        .wr_idx_i    (beat_q),
        .wr_data_i   (wbm_dat_i),
        .rd_idx_i    (rd_idx),
        .rd_data_o   (rd_data),
        .cmp_tag_i   (req_tag),
        .hit_o       (hit),
        .load_tag_i  (load_tag),
        .tag_i       (tag_q),
        .set_valid_i (set_valid),
        .clr_valid_i (clr_valid)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            pend_q  <= 1'b0;
            miss_q  <= '0;
            dat_q   <= '0;
            fill_q  <= 1'b0;
            madr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (wbs_we_i) begin
                            dat_q   <= '0;
                            state_q <= ST_RESP;
                        end else if (hit) begin
                            dat_q   <= rd_data;
                            state_q <= ST_RESP;
                        end else begin
                            tag_q   <= req_tag;
                            idx_q   <= req_idx;
                            beat_q  <= '0;
                            pend_q  <= 1'b0;
                            miss_q  <= miss_q + 16'd1;
                            fill_q  <= 1'b1;
                            madr_q  <= {req_tag, {IWL{1'b0}}, 2'b00};
                            state_q <= ST_FILL_REQ;
                        end
                    end
                end
                ST_FILL_REQ: begin
                    if (invalidate_i) begin
                        pend_q <= 1'b1;
                    end
                    if (wbm_ack_i) begin
                        fill_q <= 1'b0;
                        if (last_beat) begin
                            dat_q   <= fill_dat_d;
                            pend_q  <= 1'b0;
                            state_q <= ST_RESP;
                        end else begin
                            beat_q  <= beat_q + IWL'(1);
                            state_q <= ST_FILL_GAP;
                        end
                    end
                end
                ST_FILL_GAP: begin
                    if (invalidate_i) begin
                        pend_q <= 1'b1;
                    end
                    fill_q  <= 1'b1;
                    madr_q  <= {tag_q, beat_q, 2'b00};
                    state_q <= ST_FILL_REQ;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // An aborted upstream cycle simply gets no ack.
    assign wbs_ack_o    = (state_q == ST_RESP) & wbs_cyc_i & wbs_stb_i;
    assign wbs_dat_o    = dat_q;
    assign wbm_cyc_o    = fill_q;
    assign wbm_stb_o    = fill_q;
    assign wbm_we_o     = 1'b0;
    assign wbm_sel_o    = 4'b1111;
    assign wbm_adr_o    = madr_q;
    assign miss_count_o = miss_q;

endmodule
